sync_dualram_clr: RTL and testbench

- Parametrised synchronous simple dual-port RAM: one write port, one read port, one clock. Successor to the fixed 16x8 dual-port RAM.
- Adds a built-in clear engine that sweeps memory to INIT_VALUE after reset or on request.
- Adds a registered read with a valid flag, write-first bypass for same-address collisions, and out-of-range address detection.
- Sits as the generic storage primitive under the team's FIFO and buffer blocks.

---
 rtl/sync_dualram_pkg.sv | 28 ++
 rtl/dualram_core.sv | 33 +++
 rtl/sync_dualram_clr.sv | 188 ++++++++++++++++++
 tb/tb_sync_dualram_clr.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_dualram_pkg.sv
// Shared types and helpers for the sync_dualram_clr storage primitive.
// Optional parity storage is enabled with the SYNC_DUALRAM_PARITY_EN macro.
package sync_dualram_pkg;

  // Clear-engine FSM states
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Source of the registered read word presented on rd_data
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_CORE = 2'd1,
    SRC_BYP  = 2'd2,
    SRC_INIT = 2'd3
  } rd_src_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DEPTH      = 16;

  // Even parity: XOR-reduce of the word (callers zero-extend to 64 bits)
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/dualram_core.sv
// Bare storage array: one write port, one registered read port, no reset,
// no control. The read register only updates when re is high.
module dualram_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write stage: store the word on the rising edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read stage: registered read, holds when re is low
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_dualram_clr.sv
// Synchronous simple dual-port RAM with a clear engine, write-first bypass,
// registered read with valid flag and out-of-range address detection.
// Define SYNC_DUALRAM_PARITY_EN to store an even-parity bit per word and
// expose rd_perr.
module sync_dualram_clr
  import sync_dualram_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DEPTH      = DEF_DEPTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  addr_err
`ifdef SYNC_DUALRAM_PARITY_EN
  ,
  output logic                  rd_perr
`endif
);

`ifdef SYNC_DUALRAM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  localparam logic [ADDR_WIDTH:0]   DEPTH_V   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  logic                  ready_p0;
  logic                  wr_in_p0;
  logic                  rd_in_p0;
  logic                  wr_ok_p0;
  logic                  rd_acc_p0;
  logic                  byp_p0;
  logic                  err_p0;
  logic                  core_we_p0;
  logic                  core_re_p0;
  logic [ADDR_WIDTH-1:0] core_waddr_p0;
  logic [DATA_WIDTH-1:0] wdata_sel_p0;
  logic [WORD_W-1:0]     core_wdata_p0;

  logic [WORD_W-1:0]     core_rdata_p1;
  logic [DATA_WIDTH-1:0] byp_data_p1;
  rd_src_t               src_p1;
  logic                  vld_p1;
  logic                  err_p1;

  // FSM state register and clear address counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state: sweep every word once, then wait for a clear request
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = READY;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      READY: begin
        if (clr_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  assign busy = (state_q == CLEAR);

  // Stage p0: access qualification, range checks, bypass detect, write mux
  always_comb begin
    ready_p0      = (state_q == READY);
    wr_in_p0      = ({1'b0, wr_addr} < DEPTH_V);
    rd_in_p0      = ({1'b0, rd_addr} < DEPTH_V);
    wr_ok_p0      = ready_p0 && wr_enb && wr_in_p0;
    rd_acc_p0     = ready_p0 && rd_enb;
    byp_p0        = wr_ok_p0 && rd_acc_p0 && rd_in_p0 && (wr_addr == rd_addr);
    err_p0        = ready_p0 && ((wr_enb && !wr_in_p0) || (rd_enb && !rd_in_p0));
    core_we_p0    = busy || wr_ok_p0;
    core_re_p0    = rd_acc_p0 && rd_in_p0 && !byp_p0;
    core_waddr_p0 = busy ? clr_addr_q : wr_addr;
    wdata_sel_p0  = busy ? INIT_VALUE : wr_data;
`ifdef SYNC_DUALRAM_PARITY_EN
    core_wdata_p0 = {even_parity(64'(wdata_sel_p0)), wdata_sel_p0};
`else
    core_wdata_p0 = wdata_sel_p0;
`endif
  end

  dualram_core #(
    .DATA_WIDTH (WORD_W),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk   (clk),
    .we    (core_we_p0),
    .waddr (core_waddr_p0),
    .wdata (core_wdata_p0),
    .re    (core_re_p0),
    .raddr (rd_addr),
    .rdata (core_rdata_p1)
  );

  // Stage p1 control: valid, error pulse and read-word source selection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      src_p1 <= SRC_ZERO;
    end else begin
      vld_p1 <= rd_acc_p0;
      err_p1 <= err_p0;
      if (rd_acc_p0) begin
        if (byp_p0) begin
          src_p1 <= SRC_BYP;
        end else if (rd_in_p0) begin
          src_p1 <= SRC_CORE;
        end else begin
          src_p1 <= SRC_INIT;
        end
      end
    end
  end

  // Stage p1 data: bypass word captured on a same-address collision
  always_ff @(posedge clk) begin
    if (byp_p0) begin
      byp_data_p1 <= wr_data;
    end
  end

  // Output select: reset shows zero, otherwise the word chosen at read time
  always_comb begin
    rd_data = '0;
    case (src_p1)
      SRC_CORE: rd_data = core_rdata_p1[DATA_WIDTH-1:0];
      SRC_BYP:  rd_data = byp_data_p1;
      SRC_INIT: rd_data = INIT_VALUE;
      default:  rd_data = '0;
    endcase
  end

`ifdef SYNC_DUALRAM_PARITY_EN
  // Parity check applies only to words that actually came from storage
  always_comb begin
    rd_perr = 1'b0;
    if (src_p1 == SRC_CORE) begin
      rd_perr = core_rdata_p1[DATA_WIDTH] ^
                even_parity(64'(core_rdata_p1[DATA_WIDTH-1:0]));
    end
  end
`endif

  assign rd_valid = vld_p1;
  assign addr_err = err_p1;

endmodule

// File: tb/tb_sync_dualram_clr.sv
// Self-checking bench for sync_dualram_clr: a DEPTH=16 instance and a
// DEPTH=12 instance (INIT_VALUE=8'h5C) share one stimulus stream.
module tb_sync_dualram_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       clr_req;
  logic       wr_enb;
  logic       rd_enb;
  logic [3:0] wr_addr;
  logic [3:0] rd_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b;
  logic       busy_a, busy_b;
  logic       addr_err_a, addr_err_b;
`ifdef SYNC_DUALRAM_PARITY_EN
  logic       rd_perr_a, rd_perr_b;
`endif

  sync_dualram_clr #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .DEPTH      (16),
    .INIT_VALUE (8'h00)
  ) u_dut16 (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .wr_enb   (wr_enb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_enb   (rd_enb),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_a),
    .rd_valid (rd_valid_a),
    .busy     (busy_a),
    .addr_err (addr_err_a)
`ifdef SYNC_DUALRAM_PARITY_EN
    ,
    .rd_perr  (rd_perr_a)
`endif
  );

  sync_dualram_clr #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .DEPTH      (12),
    .INIT_VALUE (8'h5C)
  ) u_dut12 (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .wr_enb   (wr_enb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_enb   (rd_enb),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b),
    .busy     (busy_b),
    .addr_err (addr_err_b)
`ifdef SYNC_DUALRAM_PARITY_EN
    ,
    .rd_perr  (rd_perr_b)
`endif
  );

  typedef struct {
    int         dut;
    string      tag;
    logic       cd;
    logic [7:0] d;
    logic       v;
    logic       e;
  } exp_t;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic [7:0] d;
    logic       v;
  } vec_t;

  exp_t sb [$];
  vec_t tbl [9];
  int   checks = 0;
  int   errors = 0;

  task automatic check1(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", nm, act, req);
    end
  endtask

  task automatic expect_out(input int dut, input string tag, input logic cd,
                            input logic [7:0] d, input logic v, input logic e);
    exp_t x;
    x.dut = dut;
    x.tag = tag;
    x.cd  = cd;
    x.d   = d;
    x.v   = v;
    x.e   = e;
    sb.push_back(x);
  endtask

  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      if (x.dut == 0) begin
        if (x.cd) check1({x.tag, ".data"}, rd_data_a, x.d);
        check1({x.tag, ".valid"}, {7'd0, rd_valid_a}, {7'd0, x.v});
        check1({x.tag, ".err"}, {7'd0, addr_err_a}, {7'd0, x.e});
      end else begin
        if (x.cd) check1({x.tag, ".data"}, rd_data_b, x.d);
        check1({x.tag, ".valid"}, {7'd0, rd_valid_b}, {7'd0, x.v});
        check1({x.tag, ".err"}, {7'd0, addr_err_b}, {7'd0, x.e});
      end
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic re, input logic [3:0] ra, input logic cr);
    wr_enb  = we;
    wr_addr = wa;
    wr_data = wd;
    rd_enb  = re;
    rd_addr = ra;
    clr_req = cr;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic chk_busy(input string nm, input logic req);
    check1(nm, {7'd0, busy_a}, {7'd0, req});
  endtask

  task automatic chk_reset(input string nm);
    check1({nm, ".data"},  rd_data_a, 8'h00);
    check1({nm, ".valid"}, {7'd0, rd_valid_a}, 8'h00);
    check1({nm, ".err"},   {7'd0, addr_err_a}, 8'h00);
    check1({nm, ".busy"},  {7'd0, busy_a}, 8'h01);
    check1({nm, ".data12"}, rd_data_b, 8'h00);
    check1({nm, ".busy12"}, {7'd0, busy_b}, 8'h01);
  endtask

  // Runs a full clear sweep on the DEPTH=16 instance; busy must stay high
  // for exactly 16 observed cycles counting the one already observed
  task automatic busy_window(input string nm, input logic [7:0] hold_d);
    for (int k = 1; k <= 16; k++) begin
      expect_out(0, $sformatf("%s_hold%0d", nm, k), 1'b1, hold_d, 1'b0, 1'b0);
      tick();
      chk_busy($sformatf("%s_busy%0d", nm, k), (k < 16));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'hA5, 1'b1};
    tbl[2] = '{1'b1, 4'd7, 8'h3C, 1'b1, 4'd7, 8'h3C, 1'b1};
    tbl[3] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 8'h3C, 1'b1};
    tbl[4] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h3C, 1'b0};
    tbl[5] = '{1'b1, 4'd3, 8'h11, 1'b1, 4'd3, 8'h11, 1'b1};
    tbl[6] = '{1'b1, 4'd9, 8'h5A, 1'b1, 4'd3, 8'h11, 1'b1};
    tbl[7] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 8'h5A, 1'b1};
    tbl[8] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 8'h00, 1'b1};

    // power-on reset: outputs at reset values while rst is low
    idle();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2 chk_reset("por");
    @(negedge clk);
    rst = 1'b1;

    // accesses during the initial sweep must be ignored
    drive(1'b1, 4'd2, 8'hFF, 1'b1, 4'd2, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      expect_out(0, $sformatf("por_rd%0d", k), 1'b1, 8'h00, 1'b0, 1'b0);
      tick();
      chk_busy($sformatf("por_busy%0d", k), (k < 16));
    end

    // every word reads back as cleared, one cycle after rd_enb
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 1'b0);
      expect_out(0, $sformatf("sweep%0d", i), 1'b1, 8'h00, 1'b1, 1'b0);
      tick();
    end

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, 1'b0);
      expect_out(0, $sformatf("vec%0d", i), 1'b1, tbl[i].d, tbl[i].v, 1'b0);
      tick();
    end

    // clear request together with a read: the read completes, then CLEAR
    drive(1'b1, 4'd5, 8'hFF, 1'b0, 4'd0, 1'b0);
    expect_out(0, "wr5", 1'b1, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd6, 8'h99, 1'b1, 4'd5, 1'b1);
    expect_out(0, "clr_rd5", 1'b1, 8'hFF, 1'b1, 1'b0);
    tick();
    chk_busy("clr_rise", 1'b1);
    // write attempted during busy, plus a clr_req mid-sweep that must not restart it
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 4'd5, 8'h77, 1'b1, 4'd5, (k == 4) ? 1'b1 : 1'b0);
      expect_out(0, $sformatf("clr_hold%0d", k), 1'b1, 8'hFF, 1'b0, 1'b0);
      tick();
      chk_busy($sformatf("clr_busy%0d", k), (k < 16));
    end
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b0);
    expect_out(0, "post_clr_rd5", 1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 1'b0);
    expect_out(0, "post_clr_rd6", 1'b1, 8'h00, 1'b1, 1'b0);
    tick();

    // out-of-range accesses on the DEPTH=12 instance
    drive(1'b1, 4'd13, 8'hEE, 1'b0, 4'd0, 1'b0);
    expect_out(0, "oob_wr16", 1'b1, 8'h00, 1'b0, 1'b0);
    expect_out(1, "oob_wr12", 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    idle();
    expect_out(0, "oob_idle16", 1'b1, 8'h00, 1'b0, 1'b0);
    expect_out(1, "oob_idle12", 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd13, 1'b0);
    expect_out(0, "oob_rd16", 1'b1, 8'hEE, 1'b1, 1'b0);
    expect_out(1, "oob_rd12", 1'b1, 8'h5C, 1'b1, 1'b1);
    tick();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 1'b0);
    expect_out(0, "rd0_16", 1'b1, 8'h00, 1'b1, 1'b0);
    expect_out(1, "rd0_12", 1'b1, 8'h5C, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd14, 8'h01, 1'b1, 4'd1, 1'b0);
    expect_out(0, "oob_or16", 1'b1, 8'h00, 1'b1, 1'b0);
    expect_out(1, "oob_or12", 1'b1, 8'h5C, 1'b1, 1'b1);
    tick();

    // reset pulled in the 8th clear cycle
    drive(1'b1, 4'd4, 8'hC3, 1'b1, 4'd4, 1'b0);
    expect_out(0, "byp4", 1'b1, 8'hC3, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
    expect_out(0, "clr2_start", 1'b1, 8'hC3, 1'b0, 1'b0);
    tick();
    idle();
    for (int k = 2; k <= 8; k++) begin
      expect_out(0, $sformatf("clr2_hold%0d", k), 1'b1, 8'hC3, 1'b0, 1'b0);
      tick();
    end
    #3 rst = 1'b0;
    #1 chk_reset("rst_mid_sweep");
    #3 rst = 1'b1;
    busy_window("rst1", 8'h00);

    // sweep restarted from 0 and covered the whole array
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd13, 1'b0);
    expect_out(0, "rst1_rd13", 1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd4, 1'b0);
    expect_out(0, "rst1_rd4", 1'b1, 8'h00, 1'b1, 1'b0);
    tick();

    // reset pulled right after a read
    drive(1'b1, 4'd3, 8'h6B, 1'b1, 4'd3, 1'b0);
    expect_out(0, "byp3", 1'b1, 8'h6B, 1'b1, 1'b0);
    tick();
    idle();
    #3 rst = 1'b0;
    #1 chk_reset("rst_mid_read");
    #3 rst = 1'b1;
    busy_window("rst2", 8'h00);

`ifdef SYNC_DUALRAM_PARITY_EN
    drive(1'b1, 4'd2, 8'h0F, 1'b0, 4'd0, 1'b0);
    tick();
    u_dut16.u_core.mem[2][0] = ~u_dut16.u_core.mem[2][0];
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b0);
    tick();
    check1("perr_flip", {7'd0, rd_perr_a}, 8'h01);
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd1, 1'b0);
    tick();
    check1("perr_clean", {7'd0, rd_perr_a}, 8'h00);
    drive(1'b1, 4'd2, 8'h07, 1'b1, 4'd2, 1'b0);
    tick();
    check1("perr_byp", {7'd0, rd_perr_a}, 8'h00);
`endif

    idle();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
